// File: rtl/shift_reg_sequencer_pkg.sv
// Shared encodings for the shift-register sequencer.
// Optional rotate support is enabled by defining SHIFT_SEQ_ROTATE_EN.
package shift_reg_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_SHL  = 2'b10,
    OP_SHR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LEFT  = 2'b01,
    SEL_RIGHT = 2'b10,
    SEL_LOAD  = 2'b11
  } sel_e;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

endpackage

// File: rtl/shift_reg_sequencer_core.sv
// WIDTH-bit shift/load register steered by a 2-bit select.
// Module shift_reg_core; holds value on SEL_HOLD.
module shift_reg_core
  import shift_reg_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  sel_e             i_sel,
  input  logic             i_fill,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      unique case (i_sel)
        SEL_LEFT:  r_q <= {r_q[WIDTH-2:0], i_fill};
        SEL_RIGHT: r_q <= {i_fill, r_q[WIDTH-1:1]};
        SEL_LOAD:  r_q <= i_data;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer: NOP / LOAD / SHL / SHR over a shift register.
// Define SHIFT_SEQ_ROTATE_EN to honour cmd_rot (fill = exiting bit).
module shift_reg_sequencer
  import shift_reg_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_rot,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_out_valid,
  output logic [WIDTH-1:0] reg_out,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_rot;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_sov;

  op_e              w_op;
  logic             w_is_shift;
  logic             w_exit;
  logic             w_fill;
  sel_e             w_sel;
  logic [WIDTH-1:0] w_q;

  assign w_op       = op_e'(cmd_op);
  assign w_is_shift = (w_op == OP_SHL) || (w_op == OP_SHR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_cnt   <= '0;
      r_data  <= '0;
      r_rot   <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sov   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_ready) begin
            r_op    <= w_op;
            r_cnt   <= cmd_count;
            r_data  <= cmd_data;
            r_rot   <= cmd_rot;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_op == OP_LOAD) begin
              r_state <= ST_LOAD;
            end else if (w_is_shift && cmd_count != '0) begin
              r_state <= ST_SHIFT;
              r_sov   <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_DONE;
            r_sov   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Bit leaving the register this cycle; also the rotate fill.
  assign w_exit = (r_op == OP_SHL) ? w_q[WIDTH-1] : w_q[0];
  assign w_fill = (ROT_EN && r_rot) ? w_exit : ser_in;

  always_comb begin
    w_sel = SEL_HOLD;
    unique case (r_state)
      ST_LOAD:  w_sel = SEL_LOAD;
      ST_SHIFT: w_sel = (r_op == OP_SHL) ? SEL_LEFT : SEL_RIGHT;
      default:  w_sel = SEL_HOLD;
    endcase
  end

  shift_reg_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .i_sel  (w_sel),
    .i_fill (w_fill),
    .i_data (r_data),
    .o_q    (w_q)
  );

  assign cmd_ready     = r_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign ser_out_valid = r_sov;
  assign ser_out       = r_sov & w_exit;
  assign reg_out       = w_q;

endmodule
